johnson_counter_n: RTL and testbench

//  Parametrised shift-register sequence counter for timing and phase generation.
//  - Run-time mode select: Johnson (twisted-ring, period 2W) or ring (one-hot, period W).
//  - Controls: count enable, direction, synchronous parallel load.
//  - Outputs: decoded sequence index, registered wrap pulse, illegal-state flag.

---
 rtl/johnson_counter_n.sv | 99 +++++++++
 tb/tb_johnson_counter_n.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/johnson_counter_n.sv
// Johnson / ring shift-register sequence counter with load, direction, wrap pulse and illegal detect.
// Optional JCNT_SELFCORRECT_EN: an enabled step from an illegal pattern reloads the reset value.
module johnson_counter_n #(
   parameter int unsigned W = 4
) (
   input  logic                         c,
   input  logic                         r,
   input  logic                         en,
   input  logic                         dir,
   input  logic                         mode,
   input  logic                         ld,
   input  logic [W-1:0]                 ld_val,
   output logic [W-1:0]                 q,
   output logic [$clog2(2*W)-1:0]       idx,
   output logic                         wrap,
   output logic                         illegal
);

   localparam int unsigned IW      = $clog2(2*W);
   localparam logic [W-1:0] ONES    = '1;
   localparam logic [W-1:0] RST_VAL = {1'b1, {(W-1){1'b0}}};

`ifdef JCNT_SELFCORRECT_EN
   localparam bit SELFCORRECT = 1'b1;
`else
   localparam bit SELFCORRECT = 1'b0;
`endif

   logic [W-1:0]  q_q, q_d;
   logic          wrap_q, wrap_d;
   logic          legal_c;
   logic [IW-1:0] idx_c;
   logic [IW-1:0] last_idx_c;
   logic [W-1:0]  pat_c;
   logic          fb_fwd_c, fb_rev_c;

   // Decode q against every legal pattern of the current mode; illegal patterns decode to 0
   always_comb begin
      legal_c = 1'b0;
      idx_c   = '0;
      pat_c   = '0;
      if (mode) begin
         for (int unsigned i = 0; i < W; i++) begin
            pat_c = RST_VAL >> i;
            if (q_q == pat_c) begin
               legal_c = 1'b1;
               idx_c   = IW'(i);
            end
         end
      end else begin
         for (int unsigned i = 0; i < 2*W; i++) begin
            if (i < W) pat_c = ~(ONES >> (i + 1));
            else       pat_c = ~(ONES << (2*W - 1 - i));
            if (q_q == pat_c) begin
               legal_c = 1'b1;
               idx_c   = IW'(i);
            end
         end
      end
   end

   // Next state: load beats step beats hold
   always_comb begin
      q_d        = q_q;
      wrap_d     = 1'b0;
      fb_fwd_c   = mode ? q_q[0]   : ~q_q[0];
      fb_rev_c   = mode ? q_q[W-1] : ~q_q[W-1];
      last_idx_c = mode ? IW'(W - 1) : IW'(2*W - 1);
      if (ld) begin
         q_d = ld_val;
      end else if (en) begin
         if (SELFCORRECT && !legal_c) begin
            q_d = RST_VAL;
         end else if (!dir) begin
            q_d    = {fb_fwd_c, q_q[W-1:1]};
            wrap_d = legal_c && (idx_c == last_idx_c);
         end else begin
            q_d    = {q_q[W-2:0], fb_rev_c};
            wrap_d = legal_c && (idx_c == '0);
         end
      end
   end

   always_ff @(posedge c) begin
      if (r) begin
         q_q    <= RST_VAL;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   assign q       = q_q;
   assign wrap    = wrap_q;
   assign idx     = idx_c;
   assign illegal = ~legal_c;

endmodule

// File: tb/tb_johnson_counter_n.sv
// Directed scoreboard bench for johnson_counter_n at W=4.
module tb_johnson_counter_n;

   logic       clk = 1'b0;
   logic       r, en, dir, mode, ld;
   logic [3:0] ld_val;
   logic [3:0] q;
   logic [2:0] idx;
   logic       wrap, illegal;

   typedef struct {
      logic [3:0] q;
      logic [2:0] idx;
      logic       wrap;
      logic       ill;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   johnson_counter_n #(.W(4)) dut (
      .c(clk), .r(r), .en(en), .dir(dir), .mode(mode), .ld(ld), .ld_val(ld_val),
      .q(q), .idx(idx), .wrap(wrap), .illegal(illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic compare();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: empty queue, got nothing to compare");
         return;
      end
      e = sb.pop_front();
      checks++;
      assert (q === e.q) else begin
         errors++;
         $error("FAIL %s q: got %b expected %b", e.tag, q, e.q);
      end
      checks++;
      assert (idx === e.idx) else begin
         errors++;
         $error("FAIL %s idx: got %0d expected %0d", e.tag, idx, e.idx);
      end
      checks++;
      assert (wrap === e.wrap) else begin
         errors++;
         $error("FAIL %s wrap: got %b expected %b", e.tag, wrap, e.wrap);
      end
      checks++;
      assert (illegal === e.ill) else begin
         errors++;
         $error("FAIL %s illegal: got %b expected %b", e.tag, illegal, e.ill);
      end
   endtask

   // Drive controls, queue the expected post-edge result, clock once and compare
   task automatic cyc(input logic r_v, input logic ld_v, input logic en_v, input logic dir_v,
                      input logic mode_v, input logic [3:0] lv, input logic [3:0] eq,
                      input logic [2:0] ei, input logic ew, input logic eil, input string tag);
      exp_t e;
      r = r_v; ld = ld_v; en = en_v; dir = dir_v; mode = mode_v; ld_val = lv;
      e.q = eq; e.idx = ei; e.wrap = ew; e.ill = eil; e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare();
   endtask

   // Combinational-only check after a mode change with no clock edge
   task automatic now(input logic mode_v, input logic [3:0] eq, input logic [2:0] ei,
                      input logic ew, input logic eil, input string tag);
      exp_t e;
      mode = mode_v; en = 1'b0; ld = 1'b0; r = 1'b0;
      e.q = eq; e.idx = ei; e.wrap = ew; e.ill = eil; e.tag = tag;
      sb.push_back(e);
      #1;
      compare();
   endtask

   initial begin
      r = 1'b1; ld = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; ld_val = 4'h0;
      @(negedge clk);
      // Reset held two cycles
      cyc(1,0,0,0,0,4'h0, 4'b1000,0,0,0, "rst0");
      cyc(1,0,0,0,0,4'h0, 4'b1000,0,0,0, "rst1");
      // Johnson forward full cycle
      cyc(0,0,1,0,0,4'h0, 4'b1100,1,0,0, "jf1");
      cyc(0,0,1,0,0,4'h0, 4'b1110,2,0,0, "jf2");
      cyc(0,0,1,0,0,4'h0, 4'b1111,3,0,0, "jf3");
      cyc(0,0,1,0,0,4'h0, 4'b0111,4,0,0, "jf4");
      cyc(0,0,1,0,0,4'h0, 4'b0011,5,0,0, "jf5");
      cyc(0,0,1,0,0,4'h0, 4'b0001,6,0,0, "jf6");
      cyc(0,0,1,0,0,4'h0, 4'b0000,7,0,0, "jf7");
      cyc(0,0,1,0,0,4'h0, 4'b1000,0,1,0, "jf_wrap");
      // Advance to 0011 then hold five cycles
      cyc(0,0,1,0,0,4'h0, 4'b1100,1,0,0, "adv1");
      cyc(0,0,1,0,0,4'h0, 4'b1110,2,0,0, "adv2");
      cyc(0,0,1,0,0,4'h0, 4'b1111,3,0,0, "adv3");
      cyc(0,0,1,0,0,4'h0, 4'b0111,4,0,0, "adv4");
      cyc(0,0,1,0,0,4'h0, 4'b0011,5,0,0, "adv5");
      for (int i = 0; i < 5; i++) cyc(0,0,0,0,0,4'h0, 4'b0011,5,0,0, "hold");
      // Reverse from 1110 in Johnson mode
      cyc(1,0,0,0,0,4'h0, 4'b1000,0,0,0, "rst2");
      cyc(0,0,1,0,0,4'h0, 4'b1100,1,0,0, "jr_pre1");
      cyc(0,0,1,0,0,4'h0, 4'b1110,2,0,0, "jr_pre2");
      cyc(0,0,1,1,0,4'h0, 4'b1100,1,0,0, "jr1");
      cyc(0,0,1,1,0,4'h0, 4'b1000,0,0,0, "jr2");
      cyc(0,0,1,1,0,4'h0, 4'b0000,7,1,0, "jr_wrap");
      cyc(0,0,1,1,0,4'h0, 4'b0001,6,0,0, "jr4");
      // Ring mode forward, then reverse wrap
      cyc(1,0,0,0,1,4'h0, 4'b1000,0,0,0, "rst3");
      cyc(0,0,1,0,1,4'h0, 4'b0100,1,0,0, "rf1");
      cyc(0,0,1,0,1,4'h0, 4'b0010,2,0,0, "rf2");
      cyc(0,0,1,0,1,4'h0, 4'b0001,3,0,0, "rf3");
      cyc(0,0,1,0,1,4'h0, 4'b1000,0,1,0, "rf_wrap");
      cyc(0,0,1,1,1,4'h0, 4'b0001,3,1,0, "rr_wrap");
      cyc(0,0,1,1,1,4'h0, 4'b0010,2,0,0, "rr2");
      // Mode change exposes illegal pattern without a clock edge
      now(0, 4'b0010, 0, 0, 1, "mode_j_ill");
      cyc(1,0,0,0,0,4'h0, 4'b1000,0,0,0, "rst4");
      cyc(0,0,1,0,0,4'h0, 4'b1100,1,0,0, "pre_ms");
      now(1, 4'b1100, 0, 0, 1, "mode_r_ill");
`ifdef JCNT_SELFCORRECT_EN
      cyc(0,0,1,0,1,4'h0, 4'b1000,0,0,0, "ring_fix");
`else
      cyc(0,0,1,0,1,4'h0, 4'b0110,0,0,1, "ring_ill");
`endif
      // Illegal load in Johnson mode, then a step
      cyc(0,1,1,0,0,4'b1010, 4'b1010,0,0,1, "ld_ill");
`ifdef JCNT_SELFCORRECT_EN
      cyc(0,0,1,0,0,4'h0, 4'b1000,0,0,0, "ill_fix");
`else
      cyc(0,0,1,0,0,4'h0, 4'b1101,0,0,1, "ill_shift");
`endif
      // Load of last index never sets wrap; the following step does
      cyc(0,1,1,0,0,4'b0000, 4'b0000,7,0,0, "ld_last");
      cyc(0,0,1,0,0,4'h0, 4'b1000,0,1,0, "ld_wrap");
      cyc(0,1,0,0,0,4'b0111, 4'b0111,4,0,0, "ld_clr");
      // Reset beats load and enable
      cyc(1,1,1,0,0,4'b0111, 4'b1000,0,0,0, "rst_wins");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
